// File: rtl/counter_chain_if.sv
// counter_chain_if: control and status bundle for counter_chain; master drives ena/dir/clr/ld/ld_sel/ld_val, slave returns cnt/at_max/at_zero/wrap/ld_err
interface counter_chain_if #(
  parameter int NUM_STAGES = 6,
  parameter int SEL_W = 3
);
  logic ena;
  logic dir;
  logic clr;
  logic ld;
  logic [SEL_W-1:0] ld_sel;
  logic [3:0] ld_val;
  logic [4*NUM_STAGES-1:0] cnt;
  logic at_max;
  logic at_zero;
  logic wrap;
  logic ld_err;
  modport master (
    output ena, dir, clr, ld, ld_sel, ld_val,
    input cnt, at_max, at_zero, wrap, ld_err
  );
  modport slave (
    input ena, dir, clr, ld, ld_sel, ld_val,
    output cnt, at_max, at_zero, wrap, ld_err
  );
endinterface

// File: rtl/counter_chain.sv
// counter_chain: cascaded per-stage modulo counters; ports clk, res (async high), bus.slave (ena/dir/clr/ld/ld_sel/ld_val in, cnt/at_max/at_zero/wrap/ld_err out)
module counter_chain #(
  parameter int NUM_STAGES = 6,
  parameter logic [31:0] MODS = 32'h00AA6A6A,
  parameter bit SATURATE = 1'b0,
  parameter int SEL_W = 3
) (
  input logic clk,
  input logic res,
  counter_chain_if.slave bus
);
  logic [4*NUM_STAGES-1:0] cnt_q, cnt_d, stp;
  logic wrap_q, wrap_d, ld_err_q, ld_err_d;
  logic [3:0] mx [NUM_STAGES];
  logic [NUM_STAGES-1:0] st_max, st_zero;
  logic run, ld_ok;
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_st
    // a zero modulus field means 16, and 0-1 wraps to 15 in four bits
    assign mx[i] = MODS[4*i+:4] - 4'd1;
    assign st_max[i] = cnt_q[4*i+:4] == mx[i];
    assign st_zero[i] = cnt_q[4*i+:4] == 4'd0;
  end
  always_comb begin
    stp = cnt_q;
    run = 1'b1;
    ld_ok = 1'b0;
    cnt_d = cnt_q;
    wrap_d = 1'b0;
    ld_err_d = 1'b0;
    // run is the ripple enable; after the last stage it flags the chain limit
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (run)
        stp[4*k+:4] = bus.dir ? (st_zero[k] ? mx[k] : cnt_q[4*k+:4] - 4'd1)
                              : (st_max[k] ? 4'd0 : cnt_q[4*k+:4] + 4'd1);
      run = run & (bus.dir ? st_zero[k] : st_max[k]);
    end
    for (int k = 0; k < NUM_STAGES; k++)
      if (bus.ld_sel == SEL_W'(k) && bus.ld_val <= mx[k]) ld_ok = 1'b1;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.ld) begin
      ld_err_d = !ld_ok;
      for (int k = 0; k < NUM_STAGES; k++)
        if (ld_ok && bus.ld_sel == SEL_W'(k)) cnt_d[4*k+:4] = bus.ld_val;
    end else if (bus.ena) begin
      wrap_d = run;
      cnt_d = (SATURATE && run) ? cnt_q : stp;
    end
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= '0;
      wrap_q <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end
  assign bus.cnt = cnt_q;
  assign bus.at_max = &st_max;
  assign bus.at_zero = &st_zero;
  assign bus.wrap = wrap_q;
  assign bus.ld_err = ld_err_q;
endmodule
